// File: rtl/reg8_pkg.sv
// Shared definitions for the 8x8 register-file access engine.
package reg8_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;
    localparam int SUM_W  = 11;

    typedef enum logic [1:0] {
        OP_FILL = 2'b00,
        OP_COPY = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    // Counts above the register file depth clamp to a full sweep.
    function automatic logic [3:0] sat_len(input logic [3:0] l);
        return (l > 4'd8) ? 4'd8 : l;
    endfunction

endpackage

// File: rtl/reg8_mover.sv
// Bulk FILL/COPY/SUM engine driving the write and read ports of the 8x8 register file.
// Every output is a register; COPY stages read data directly in rf_d.
module reg8_mover
    import reg8_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [REG_AW-1:0]   src,
    input  logic [REG_AW-1:0]   dst,
    input  logic [3:0]          len,
    input  logic [REG_DW-1:0]   imm,
    input  logic [REG_DW-1:0]   rf_q,
    output logic                rf_en,
    output logic [REG_AW-1:0]   rf_wsel,
    output logic [REG_AW-1:0]   rf_rsel,
    output logic [REG_DW-1:0]   rf_d,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    sum
);

    state_e              state_q;
    op_e                 op_q;
    logic [REG_AW-1:0]   src_q, dst_q, idx_q;
    logic [3:0]          len_q;
    logic                en_q, busy_q, done_q;
    logic [REG_AW-1:0]   wsel_q, rsel_q;
    logic [REG_DW-1:0]   d_q;
    logic [SUM_W-1:0]    sum_q;

    logic                last;
    logic [REG_AW-1:0]   src_nxt, dst_cur, dst_nxt;
    logic [3:0]          len_in;

    // 3-bit adders give the modulo-8 address wrap for free.
    assign last    = (({1'b0, idx_q} + 4'd1) == len_q);
    assign src_nxt = src_q + idx_q + 3'd1;
    assign dst_cur = dst_q + idx_q;
    assign dst_nxt = dst_q + idx_q + 3'd1;
    assign len_in  = sat_len(len);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            op_q    <= OP_FILL;
            src_q   <= '0;
            dst_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wsel_q  <= '0;
            rsel_q  <= '0;
            d_q     <= '0;
            sum_q   <= '0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op_e'(op);
                        src_q  <= src;
                        dst_q  <= dst;
                        len_q  <= len_in;
                        idx_q  <= '0;
                        sum_q  <= '0;
                        busy_q <= 1'b1;
                        if (len_in == 4'd0 || op_e'(op) == OP_RSV) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else if (op_e'(op) == OP_FILL) begin
                            state_q <= ST_WR;
                            en_q    <= 1'b1;
                            wsel_q  <= dst;
                            d_q     <= imm;
                        end else begin
                            state_q <= ST_RD;
                            rsel_q  <= src;
                        end
                    end
                end
                ST_RD: begin
                    if (op_q == OP_COPY) begin
                        d_q     <= rf_q;
                        en_q    <= 1'b1;
                        wsel_q  <= dst_cur;
                        state_q <= ST_WR;
                    end else begin
                        sum_q <= sum_q + {3'b000, rf_q};
                        if (last) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            rsel_q <= src_nxt;
                        end
                    end
                end
                ST_WR: begin
                    if (last) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        if (op_q == OP_FILL) begin
                            en_q   <= 1'b1;
                            wsel_q <= dst_nxt;
                        end else begin
                            state_q <= ST_RD;
                            rsel_q  <= src_nxt;
                        end
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rf_en   = en_q;
    assign rf_wsel = wsel_q;
    assign rf_rsel = rsel_q;
    assign rf_d    = d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;

endmodule

// File: doc/reg8_mover.md
# reg8_mover

Command-driven access engine that acts as the initiator on the write/read ports of the 8×8-bit register file. It accepts one bulk operation at a time: FILL a range with a constant, COPY a range, or SUM a range. It then sequences the register file's en/wsel/d and rsel/q ports itself. It sits between the lab's control logic (switches/FSM) and the register file, replacing hand-driven wsel/rsel.

## Interface
- No parameters; widths are fixed by the register file: 8 registers, 8-bit data, 3-bit address.
- clk  in  1  rising-edge clock
- clr  in  1  reset clr, asynchronous, active-high
- start  in  1  command strobe; sampled only while idle
- op  in  2  00 FILL, 01 COPY, 10 SUM, 11 reserved
- src  in  3  first source register (COPY, SUM)
- dst  in  3  first destination register (FILL, COPY)
- len  in  4  element count: 0 means none, 1–8 as given, 9–15 saturate to 8
- imm  in  8  fill value (FILL)
- rf_q  in  8  register file read data, combinational from rf_rsel
- rf_en  out  1  register file write enable
- rf_wsel  out  3  register file write address
- rf_rsel  out  3  register file read address
- rf_d  out  8  register file write data
- busy  out  1  high whenever not idle
- done  out  1  one-cycle completion pulse
- sum  out  11  SUM result; holds until the next accepted start

## Operation
- **Latching:** every output is a register. At an accepted start (start=1 in IDLE), latch op/src/dst/imm and the saturated len into internal registers. Clear sum and the element index i at the same time.
- **Address wrap:** element addresses are src+i and dst+i, modulo 8 (3-bit wrap). Example: src=6, len=4 touches 6, 7, 0, 1.
- **States:** IDLE, RD, WR, FIN.
- **IDLE:**
  - len==0 or op==11 → FIN; no register file access.
  - FILL → WR.
  - COPY or SUM → RD, with rf_rsel ← src.
- **RD:**
  - rf_q is valid for the address held in rf_rsel.
  - COPY: data_r ← rf_q, then → WR.
  - SUM: sum ← sum + rf_q. If i is the last element → FIN; else i++, rf_rsel ← src+i+1, stay in RD.
- **WR:**
  - rf_en=1, rf_wsel=dst+i, rf_d=imm (FILL) or data_r (COPY).
  - Last element → FIN.
  - Otherwise i++. FILL stays in WR; COPY → RD with rf_rsel ← src+i+1.
- **FIN:** done=1 for exactly one cycle, then → IDLE.
- **rf_en:** high only in WR cycles; 0 in every other state.
- **Overlapping COPY:** elements are processed strictly in ascending i, one read then one write. Consequence: dst=src+1, len=3 over {A,B,C} yields A,A,A,A (ripple); dst=src is a harmless self-copy.
- **Arithmetic:** sum is 11 bits unsigned; the maximum is 8×255=2040, so no overflow is possible.
- **start while busy:** ignored, no queueing. Inputs may change freely after acceptance.

## Timing
- **Reset (clr):**
  - Forces state=IDLE.
  - Clears rf_en, rf_wsel, rf_rsel, rf_d, busy, done, sum and internal registers to 0, effective immediately.
  - Mid-operation reset aborts the command: no further writes, no done pulse, and elements already written stay written.
- **Cycle counts** (start sampled at edge 0, N = effective len):
  - FILL: writes on edges 1..N, done high in cycle N+1, busy high in cycles 1..N+1.
  - COPY: 2N cycles of RD/WR, done in cycle 2N+1.
  - SUM: N RD cycles, done in cycle N+1, final sum valid from the same edge as done.
  - len=0 or reserved op: done in cycle 1, busy high for that one cycle only.
- **New command:** a start sampled on the edge leaving FIN is not accepted. The earliest accepted new start is in the first IDLE cycle.

## Structure
- **Shared package** reg8_pkg holds:
  - op codes: OP_FILL, OP_COPY, OP_SUM, OP_RSV
  - state encoding: ST_IDLE, ST_RD, ST_WR, ST_FIN
  - width constants: REG_AW=3, REG_DW=8, SUM_W=11
- **Sub-modules:** none required; the FSM, index counter and wrap adders are inline.
- **Bench:** instantiates this block together with the existing 8×8 register file, connected port-to-port.

## Test plan
- **FILL:** reset, then FILL dst=5, len=3, imm=8'hA5 → writes on three consecutive edges to 5, 6, 7. Done in cycle 4, then registers 5–7 read A5 and all others read 00.
- **SUM with wrap:** preload r6=10, r7=20, r0=30, r1=40, then SUM src=6, len=4 → sum=100, done in cycle 5, and rf_en never asserted.
- **Overlapping COPY:** preload r0=1, r1=2, r2=3, then COPY src=0, dst=1, len=3 → r1=r2=r3=1. Done in cycle 7, exactly 3 write cycles.
- **Saturation and degenerate commands:**
  - len=12 FILL → exactly 8 writes, all registers = imm.
  - len=0 → done in cycle 1, no writes.
  - op=11 → done in cycle 1, no writes.
- **Reset and busy handling:**
  - clr asserted during the 2nd element of a COPY len=4 → rf_en falls immediately, no done, 1st destination updated, 2nd–4th unchanged.
  - start pulsed while busy → ignored, one done only.
- **SUM maximum:** all registers 8'hFF, SUM len=8 → sum=2040 (11'h7F8).
